snitch_sb_retire: RTL

// - Completion/retire side of the FPU scoreboard. FPU results carry the scoreboard entry index

---
 rtl/snitch_sb_retire.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/snitch_sb_retire.sv
// FPU completion/retire queue: buffers results in order, drains them to the FP regfile write
// port and frees the matching scoreboard entry on every accepted write.
// Optional same-cycle bypass when empty: define SNITCH_SB_RETIRE_BYPASS_EN.
module snitch_sb_retire #(
   parameter int unsigned AddrWidth  = 5,
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned Depth      = 8,
   parameter int unsigned QueueDepth = 4,
   localparam int unsigned IdxWidth   = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned UsageWidth = $clog2(QueueDepth + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cpl_valid_i,
   output logic                  cpl_ready_o,
   input  logic [IdxWidth-1:0]   cpl_idx_i,
   input  logic [AddrWidth-1:0]  cpl_rd_i,
   input  logic [DataWidth-1:0]  cpl_data_i,
   output logic                  wb_valid_o,
   input  logic                  wb_ready_i,
   output logic [AddrWidth-1:0]  wb_rd_o,
   output logic [DataWidth-1:0]  wb_data_o,
   output logic                  pop_valid_o,
   output logic [IdxWidth-1:0]   pop_index_o,
   output logic [UsageWidth-1:0] usage_o
);

   localparam int unsigned PtrWidth = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
   localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(QueueDepth - 1);
   localparam logic [UsageWidth-1:0] FullCount = UsageWidth'(QueueDepth);

   typedef struct packed {
      logic [IdxWidth-1:0]  idx;
      logic [AddrWidth-1:0] rd;
      logic [DataWidth-1:0] data;
   } entry_t;

   entry_t                slot_q [QueueDepth];
   entry_t                cpl_entry;
   entry_t                head_entry;
   entry_t                out_entry;
   logic [PtrWidth-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [PtrWidth-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [UsageWidth-1:0] count_reg, count_next;
   logic                  empty;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  retire;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   assign cpl_entry  = '{idx: cpl_idx_i, rd: cpl_rd_i, data: cpl_data_i};
   assign head_entry = slot_q[rd_ptr_reg];
   assign empty      = (count_reg == '0);
   assign full       = (count_reg == FullCount);

   // Storage slots: each one captures the completion when the write pointer selects it.
   for (genvar gi = 0; gi < QueueDepth; gi++) begin : g_slot
      entry_t slot_reg;
      always_ff @(posedge clk_i) begin
         if (push && (wr_ptr_reg == PtrWidth'(gi))) begin
            slot_reg <= cpl_entry;
         end
      end
      assign slot_q[gi] = slot_reg;
   end

`ifdef SNITCH_SB_RETIRE_BYPASS_EN
   logic bypass;
   // Empty queue with a ready regfile: the completion retires directly and is never stored.
   assign bypass      = empty & cpl_valid_i & wb_ready_i;
   assign cpl_ready_o = ~full;
   assign wb_valid_o  = ~empty | cpl_valid_i;
   assign out_entry   = empty ? cpl_entry : head_entry;
   assign push        = cpl_valid_i & cpl_ready_o & ~bypass;
   assign pop         = ~empty & wb_ready_i;
`else
   assign cpl_ready_o = ~full;
   assign wb_valid_o  = ~empty;
   assign out_entry   = head_entry;
   assign push        = cpl_valid_i & cpl_ready_o;
   assign pop         = ~empty & wb_ready_i;
`endif

   assign retire      = wb_valid_o & wb_ready_i;
   assign pop_valid_o = retire;
   assign pop_index_o = retire ? out_entry.idx : '0;
   assign wb_rd_o     = wb_valid_o ? out_entry.rd : '0;
   assign wb_data_o   = wb_valid_o ? out_entry.data : '0;
   assign usage_o     = count_reg;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push) begin
         wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
         rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

`ifndef SYNTHESIS
   logic   stall_reg;
   entry_t stall_entry_reg;
   // A stalled completion must keep its payload until accepted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_reg       <= 1'b0;
         stall_entry_reg <= '0;
      end else begin
         stall_reg       <= cpl_valid_i & ~cpl_ready_o;
         stall_entry_reg <= cpl_entry;
         if (stall_reg && cpl_valid_i && (cpl_entry != stall_entry_reg)) begin
            $display("%m warning: completion payload changed while stalled");
         end
         if (cpl_valid_i && (int'(cpl_idx_i) >= int'(Depth))) begin
            $display("%m warning: completion index %0d out of range", cpl_idx_i);
         end
      end
   end
`endif

endmodule
